// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared CPU defines for the hazard controller
// Purpose: FSM state encodings, MemRead "not a load" code and the
//          multiply/divide counter width and load-value helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_BUSY = 2'b01,
        ST_MD_DONE = 2'b10
    } hz_state_e;

    // MemRead_exe code for "EXE instruction is not a load".
    localparam logic [1:0] MEM_NONE = 2'b00;

    // Wide enough for DIV_CYCLES-1 up to 63.
    localparam int MD_CNT_W = 6;

    // Counter value loaded on an md start: the start cycle itself is the
    // first stall cycle, so the counter covers the remaining cycles.
    function automatic logic [MD_CNT_W-1:0] md_cnt_load(
        input logic is_div,
        input int   mul_cycles,
        input int   div_cycles
    );
        int cycles;
        cycles = is_div ? div_cycles : mul_cycles;
        return MD_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// rtl/hazard_ctrl_load_use.sv - combinational load-use hazard comparator
// Purpose: flags an ID-stage source operand produced by a load in EXE.
// Ports:
//   rs_id_i, rt_id_i   ID-stage source register numbers
//   rd_exe_i           EXE-stage destination register
//   reg_write_exe_i    EXE instruction writes the register file
//   mem_read_exe_i     EXE load type (MEM_NONE = not a load)
//   load_use_o         hazard present this cycle
module load_use_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_id_i,
    input  logic [4:0] rt_id_i,
    input  logic [4:0] rd_exe_i,
    input  logic       reg_write_exe_i,
    input  logic [1:0] mem_read_exe_i,
    output logic       load_use_o
);

    logic is_load;
    logic src_match;

    assign is_load   = (mem_read_exe_i != MEM_NONE) && reg_write_exe_i;
    assign src_match = (rd_exe_i == rs_id_i) || (rd_exe_i == rt_id_i);

    // $zero is never a real dependency.
    assign load_use_o = is_load && (rd_exe_i != 5'd0) && src_match;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (load-use, mult/div, branch)
// Purpose: generates stall/flush controls for a 5-stage pipeline and
//          sequences the multi-cycle multiply/divide occupancy of EXE.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rs_id, rt_id, rd_exe          register numbers for hazard compare
//   RegWrite_exe, MemRead_exe     EXE instruction write/load info
//   branch_taken_id               taken branch/jump resolved in ID
//   md_start_exe, md_is_div_exe   mult/div present in EXE, div select
//   stall_pc/ifid/idex            hold the PC and pipeline registers
//   flush_ifid/idex/exmem         bubble insertion
//   md_busy                       multi-cycle unit occupying EXE
//   state_dbg                     current FSM state
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic [4:0] rd_exe,
    input  logic       RegWrite_exe,
    input  logic [1:0] MemRead_exe,
    input  logic       branch_taken_id,
    input  logic       md_start_exe,
    input  logic       md_is_div_exe,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       stall_idex,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       flush_exmem,
    output logic       md_busy,
    output logic [1:0] state_dbg
);

    hz_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic [MD_CNT_W-1:0]   md_load;
    logic                  load_use;
    logic                  md_active;
    logic                  lu_active;
    logic                  br_flush;

    load_use_detect u_load_use (
        .rs_id_i        (rs_id),
        .rt_id_i        (rt_id),
        .rd_exe_i       (rd_exe),
        .reg_write_exe_i(RegWrite_exe),
        .mem_read_exe_i (MemRead_exe),
        .load_use_o     (load_use)
    );

    assign md_load = md_cnt_load(md_is_div_exe, MUL_CYCLES, DIV_CYCLES);

    // Next state. The counter holds the number of MD_BUSY cycles still to
    // come, so the start cycle plus the MD_BUSY cycles equal the full count.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (md_start_exe) begin
                    md_cnt_d = md_load;
                    state_d  = (md_load == '0) ? ST_MD_DONE : ST_MD_BUSY;
                end
            end
            ST_MD_BUSY: begin
                md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - 1'b1 : '0;
                if (md_cnt_q <= MD_CNT_W'(1)) begin
                    state_d = ST_MD_DONE;
                end
            end
            // The finished md instruction is still visible in EXE here, so
            // md_start_exe must not re-trigger; the next md starts from RUN.
            ST_MD_DONE: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Output priority: md occupancy > load-use > branch flush. A branch
    // seen while stalled is simply re-presented by ID once the stall drops.
    assign md_active = !rst && (((state_q == ST_RUN) && md_start_exe) ||
                                (state_q == ST_MD_BUSY));
    assign lu_active = !rst && (state_q == ST_RUN) && !md_start_exe && load_use;
    assign br_flush  = !rst && !md_active && !lu_active && branch_taken_id;

    assign stall_pc    = md_active || lu_active;
    assign stall_ifid  = md_active || lu_active;
    assign stall_idex  = md_active;
    assign flush_ifid  = br_flush;
    assign flush_idex  = lu_active;
    assign flush_exmem = md_active;
    assign md_busy     = md_active;
    assign state_dbg   = state_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, EXE-stage cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 32, EXE-stage cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports rs_id, rt_id  input  5  source register numbers of the ID-stage instruction.
REQ-006 SHALL have port rd_exe  input  5  destination register of the EXE-stage instruction.
REQ-007 SHALL have port RegWrite_exe  input  1  EXE instruction writes the register file.
REQ-008 SHALL have port MemRead_exe  input  2  EXE load type; 00 means not a load (lw/lh/lb are nonzero).
REQ-009 SHALL have port branch_taken_id  input  1  branch/jump in ID resolved taken.
REQ-010 SHALL have port md_start_exe  input  1  mult/div instruction present in EXE.
REQ-011 SHALL have port md_is_div_exe  input  1  1 selects DIV_CYCLES, 0 selects MUL_CYCLES.
REQ-012 SHALL have ports stall_pc, stall_ifid, stall_idex  output  1 each  hold PC, IF/ID, and ID/EX registers.
REQ-013 SHALL have ports flush_ifid, flush_idex, flush_exmem  output  1 each  insert a bubble into that pipeline register.
REQ-014 SHALL have port md_busy  output  1  multi-cycle unit is occupying EXE.
REQ-015 SHALL have port state_dbg  output  2  current FSM state encoding.

Function
REQ-016 SHALL implement FSM states RUN=00, MD_BUSY=01, MD_DONE=10, and a 6-bit down-counter md_cnt.
REQ-017 SHALL detect load-use in RUN when MemRead_exe!=00, RegWrite_exe=1, rd_exe!=0, and (rd_exe==rs_id or rd_exe==rt_id); it shall assert stall_pc=stall_ifid=flush_idex=1 combinationally in the same cycle.
REQ-018 SHALL leave load-to-use distance 2 (load in MEM) to forwarding with no stall.
REQ-019 SHALL NOT stall on rd_exe==0 under any condition.
REQ-020 SHALL transition RUN->MD_BUSY on md_start_exe=1, loading md_cnt with (md_is_div_exe ? DIV_CYCLES : MUL_CYCLES)-1.
REQ-021 SHALL, in the md_start_exe cycle and every MD_BUSY cycle, assert stall_pc, stall_ifid, stall_idex, flush_exmem, and md_busy.
REQ-022 SHALL decrement md_cnt once per cycle in MD_BUSY; at md_cnt==0 it shall go to MD_DONE at the next edge.
REQ-023 SHALL, in MD_DONE, deassert all stalls and md_busy, ignore md_start_exe (same instruction still visible), and return to RUN next cycle.
REQ-024 SHALL make total stall cycles for one mult equal MUL_CYCLES and for one div equal DIV_CYCLES.
REQ-025 SHALL assert flush_ifid when branch_taken_id=1 and no stall is active that cycle; while stalled, branch flush is suppressed and re-evaluated when the stall releases.
REQ-026 SHALL apply priority MD start/MD_BUSY > load-use > branch flush; simultaneous load-use and md_start_exe is impossible (single EXE) and the md path wins.
REQ-027 SHALL ensure back-to-back md instructions each take a full count: the second is accepted only from RUN.
REQ-028 SHALL keep md_cnt unchanged in RUN and MD_DONE.
REQ-029 SHALL expose the state encoding on state_dbg.

Reset
REQ-030 SHALL force state=RUN and md_cnt=0 at the clock edge where rst=1, including mid-MD_BUSY.
REQ-031 SHALL drive all stall_*, flush_*, and md_busy outputs to 0 during any cycle with rst=1, and state_dbg to 00 after reset.

Structure
REQ-032 SHALL place the state encodings (RUN/MD_BUSY/MD_DONE) and MemRead code 00 (MEM_NONE) in the shared CPU defines package.
REQ-033 SHALL keep the load-use comparator as a combinational sub-module, load_use_detect; the FSM/counter and output muxing shall stay in hazard_ctrl.

Verification
REQ-034 SHALL check: lw $3 in EXE (MemRead_exe=01, rd_exe=3), rs_id=3 -> stall_pc=stall_ifid=flush_idex=1 for exactly 1 cycle; with rd_exe=0, no stall.
REQ-035 SHALL check: md_start_exe=1, md_is_div_exe=1 held -> md_busy high for exactly 32 cycles, one MD_DONE cycle with no stall, then RUN, and no restart.
REQ-036 SHALL check: mult (md_is_div_exe=0) -> 4 stall cycles, flush_exmem high in each.
REQ-037 SHALL check: branch_taken_id=1 during MD_BUSY -> flush_ifid=0 until MD_DONE, then 1.
REQ-038 SHALL check: rst=1 at md_cnt=10 in MD_BUSY -> next cycle state_dbg=00, all outputs 0, a new div restarts the count at 31.
REQ-039 SHALL check: two consecutive divs -> 64 total stall cycles separated by exactly one MD_DONE cycle.
